axi_lite_traffic_gen: RTL and testbench
=======================================

# axi_lite_traffic_gen

Parametrised AXI4-Lite manager that generates and self-checks transactions against an AXI-Lite subordinator (for example `axi_subordinator`). It writes a seeded incrementing pattern over an address range, reads the range back and compares every word. It counts response and data errors and guards every handshake wait with a timeout. It replaces hand-written per-address read/write sequences and runs in simulation and in on-chip bring-up.

## Interface
Parameters:
- `ABUS_SIZE`, 5: address width.
- `DBUS_SIZE`, 32: data width.
- `NUM_TXN`, 4: words per run, ≥1.
- `BASE_ADDR`, 0: first address.
- `ADDR_STRIDE`, 1: address increment per word.
- `TIMEOUT`, 64: maximum cycles to wait on any single handshake, ≥2.
- `CW`: derived, `$clog2(2*NUM_TXN+1)`; error counter width.

Ports:
- `ACLK` in 1: clock; every register updates on its rising edge.
- `ARESET` in 1: synchronous, active-high reset.
- `start` in 1: run request; sampled only in IDLE.
- `mode` in 2: 0 write-only, 1 read-check-only, 2 interleaved write/read per word, 3 write all then read all. Latched at start.
- `seed` in DBUS_SIZE: pattern base; latched at start.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse at the end of a run.
- `pass` out 1: the last run had no errors and no timeout.
- `err_count` out CW: number of errors in the last run.
- `timeout` out 1: the last run aborted on a timeout.
- Manager side: `AWADDR` out ABUS_SIZE, `AWVALID` out 1, `AWREADY` in 1, `WDATA` out DBUS_SIZE, `WVALID` out 1, `WREADY` in 1, `BRESP` in 2, `BVALID` in 1, `BREADY` out 1, `ARADDR` out ABUS_SIZE, `ARVALID` out 1, `ARREADY` in 1, `RDATA` in DBUS_SIZE, `RRESP` in 2, `RVALID` in 1, `RREADY` out 1.

## Operation
- Word i (0..NUM_TXN-1):
  - address = (BASE_ADDR + i*ADDR_STRIDE) mod 2^ABUS_SIZE, so addresses wrap silently.
  - data = (seed + i) mod 2^DBUS_SIZE.
- States: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, NEXT, FIN.
- IDLE + start=1 → first state for the mode: WR_REQ for modes 0, 2 and 3; RD_ADDR for mode 1. The same transition clears `err_count`, `pass` and `timeout` and sets the index to 0.
- WR_REQ:
  - Drive `AWVALID`=`WVALID`=1 together, with the address and data for the current index.
  - Each valid drops independently on its own handshake (valid & ready at an edge).
  - Move to WR_RESP once both handshakes have completed, in either order or in the same cycle.
- WR_RESP: `BREADY`=1. On `BVALID`, BRESP≠0 increments `err_count`. Next state: RD_ADDR in mode 2, otherwise NEXT.
- RD_ADDR: `ARVALID`=1 until `ARREADY`, then move to RD_DATA.
- RD_DATA:
  - `RREADY`=1.
  - On `RVALID`, increment `err_count` once if RRESP≠0 or RDATA≠expected data. A word with both faults counts once.
  - Next state: NEXT.
- NEXT:
  - If the index is not last: index+1, then WR_REQ (modes 0, 2 and the write phase of 3) or RD_ADDR (mode 1 and the read phase of 3).
  - If last in mode 3 write phase: index←0, read phase, RD_ADDR.
  - Otherwise: FIN.
- FIN: `done`=1 for one cycle, `pass`=(err_count==0 && !timeout), then IDLE.
- Timeout:
  - A counter clears on entry to each of WR_REQ, WR_RESP, RD_ADDR and RD_DATA and increments every cycle spent there.
  - When it reaches TIMEOUT without completing the state: drop all valids and readies, set `timeout`=1, go to FIN.
- `err_count` saturates at 2^CW−1.
- `start` outside IDLE is ignored.

## Timing
- Reset values: all valids and readies 0, `AWADDR`/`ARADDR`/`WDATA` 0, `busy`=`done`=`pass`=`timeout`=0, `err_count`=0, state IDLE.
- `ARESET` mid-run: at the next edge every output takes its reset value. No outstanding transaction is completed. A `start` coincident with `ARESET` is ignored.
- `busy` and the first VALID rise at the edge after the edge that sampled `start`. `busy` falls with `done`.
- Zero-wait subordinator, per word:
  - Write: 1 cycle WR_REQ + 1 cycle WR_RESP + 1 cycle NEXT.
  - Read: 1 cycle RD_ADDR + 1 cycle RD_DATA + 1 cycle NEXT.
- Valids never deassert before their handshake, except on timeout or reset. Address and data stay stable while valid is high.
- Only one transaction is outstanding at a time; no read overlaps a write.

## Test plan
- Mode 2, seed=0x10, defaults, zero-wait RAM → RAM[0..3]=0x10..0x13, 4 writes and 4 reads interleaved, `done` once, `pass`=1, `err_count`=0.
- Mode 1, seed=0, RAM[i]=i preloaded → `pass`=1. Then RAM[2]=0xFF → `err_count`=1, `pass`=0.
- Mode 3, AWREADY/WREADY delayed 3 cycles → all 4 B handshakes complete before the first ARVALID, `pass`=1. WREADY before AWREADY is also accepted.
- ARREADY tied low, TIMEOUT=16 → `ARVALID` low after 16 cycles in RD_ADDR, `timeout`=1, `pass`=0, `done` pulses.
- BASE_ADDR=30, NUM_TXN=4, mode 0 → AWADDR sequence 30,31,0,1. BRESP=2 injected on the second write → `err_count`=1.
- `ARESET` asserted during WR_RESP → all outputs at reset values the next cycle, `busy`=0. A new run after release passes.

Source files
------------

// File: rtl/axi_lite_traffic_gen.sv
// AXI4-Lite manager that writes a seeded incrementing pattern over an address range,
// reads it back, and counts response/data errors with a per-handshake timeout.
module axi_lite_traffic_gen #(
   parameter int ABUS_SIZE   = 5,
   parameter int DBUS_SIZE   = 32,
   parameter int NUM_TXN     = 4,
   parameter int BASE_ADDR   = 0,
   parameter int ADDR_STRIDE = 1,
   parameter int TIMEOUT     = 64,
   localparam int CW         = $clog2(2 * NUM_TXN + 1)
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   input  logic                 start,
   input  logic [1:0]           mode,
   input  logic [DBUS_SIZE-1:0] seed,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CW-1:0]        err_count,
   output logic                 timeout,
   output logic [ABUS_SIZE-1:0] AWADDR,
   output logic                 AWVALID,
   input  logic                 AWREADY,
   output logic [DBUS_SIZE-1:0] WDATA,
   output logic                 WVALID,
   input  logic                 WREADY,
   input  logic [1:0]           BRESP,
   input  logic                 BVALID,
   output logic                 BREADY,
   output logic [ABUS_SIZE-1:0] ARADDR,
   output logic                 ARVALID,
   input  logic                 ARREADY,
   input  logic [DBUS_SIZE-1:0] RDATA,
   input  logic [1:0]           RRESP,
   input  logic                 RVALID,
   output logic                 RREADY
);

   localparam int IW = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      StIdle, StWrReq, StWrResp, StRdAddr, StRdData, StNext, StFin
   } state_e;

   state_e               state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [1:0]           mode_q, mode_d;
   logic [DBUS_SIZE-1:0] seed_q, seed_d;
   logic                 start_q, start_d;
   logic                 rd_phase_q, rd_phase_d;
   logic                 aw_done_q, aw_done_d;
   logic                 w_done_q, w_done_d;
   logic [TW-1:0]        tcnt_q, tcnt_d;
   logic [CW-1:0]        err_q, err_d;
   logic                 pass_q, pass_d;
   logic                 timeout_q, timeout_d;

   logic [ABUS_SIZE-1:0] cur_addr;
   logic [DBUS_SIZE-1:0] cur_data;
   logic                 last_idx;
   logic                 tmo_hit;
   logic                 err_inc;

   assign cur_addr = ABUS_SIZE'(BASE_ADDR + int'(idx_q) * ADDR_STRIDE);
   assign cur_data = seed_q + DBUS_SIZE'(idx_q);
   assign last_idx = (int'(idx_q) == NUM_TXN - 1);
   assign tmo_hit  = (int'(tcnt_q) == TIMEOUT - 1);

   // Address/data are forced to zero outside their request states so idle outputs are clean.
   assign AWVALID   = (state_q == StWrReq) && !aw_done_q;
   assign WVALID    = (state_q == StWrReq) && !w_done_q;
   assign AWADDR    = (state_q == StWrReq) ? cur_addr : '0;
   assign WDATA     = (state_q == StWrReq) ? cur_data : '0;
   assign BREADY    = (state_q == StWrResp);
   assign ARVALID   = (state_q == StRdAddr);
   assign ARADDR    = (state_q == StRdAddr) ? cur_addr : '0;
   assign RREADY    = (state_q == StRdData);
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StFin);
   assign pass      = pass_q;
   assign err_count = err_q;
   assign timeout   = timeout_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      mode_d     = mode_q;
      seed_d     = seed_q;
      start_d    = 1'b0;
      rd_phase_d = rd_phase_q;
      aw_done_d  = 1'b0;
      w_done_d   = 1'b0;
      tcnt_d     = '0;
      err_d      = err_q;
      pass_d     = pass_q;
      timeout_d  = timeout_q;
      err_inc    = 1'b0;

      unique case (state_q)
         StIdle: begin
            // start is captured one edge before launch so busy/valid rise an edge later.
            start_d = start && !start_q;
            if (start_d) begin
               mode_d = mode;
               seed_d = seed;
            end
            if (start_q) begin
               idx_d      = '0;
               rd_phase_d = 1'b0;
               err_d      = '0;
               pass_d     = 1'b0;
               timeout_d  = 1'b0;
               state_d    = (mode_q == 2'd1) ? StRdAddr : StWrReq;
            end
         end
         StWrReq: begin
            aw_done_d = aw_done_q || AWREADY;
            w_done_d  = w_done_q || WREADY;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = StWrResp;
            end else if (tmo_hit) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               timeout_d = 1'b1;
               state_d   = StFin;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         StWrResp: begin
            if (BVALID) begin
               err_inc = (BRESP != 2'b00);
               state_d = (mode_q == 2'd2) ? StRdAddr : StNext;
            end else if (tmo_hit) begin
               timeout_d = 1'b1;
               state_d   = StFin;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         StRdAddr: begin
            if (ARREADY) begin
               state_d = StRdData;
            end else if (tmo_hit) begin
               timeout_d = 1'b1;
               state_d   = StFin;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         StRdData: begin
            if (RVALID) begin
               err_inc = (RRESP != 2'b00) || (RDATA != cur_data);
               state_d = StNext;
            end else if (tmo_hit) begin
               timeout_d = 1'b1;
               state_d   = StFin;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         StNext: begin
            if (!last_idx) begin
               idx_d   = idx_q + 1'b1;
               state_d = ((mode_q == 2'd1) || ((mode_q == 2'd3) && rd_phase_q)) ?
                         StRdAddr : StWrReq;
            end else if ((mode_q == 2'd3) && !rd_phase_q) begin
               idx_d      = '0;
               rd_phase_d = 1'b1;
               state_d    = StRdAddr;
            end else begin
               state_d = StFin;
            end
         end
         StFin: begin
            pass_d  = (err_q == '0) && !timeout_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (err_inc && (err_q != '1)) begin
         err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         mode_q     <= 2'd0;
         seed_q     <= '0;
         start_q    <= 1'b0;
         rd_phase_q <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         tcnt_q     <= '0;
         err_q      <= '0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         mode_q     <= mode_d;
         seed_q     <= seed_d;
         start_q    <= start_d;
         rd_phase_q <= rd_phase_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         tcnt_q     <= tcnt_d;
         err_q      <= err_d;
         pass_q     <= pass_d;
         timeout_q  <= timeout_d;
      end
   end

endmodule

// File: tb/tb_axi_lite_traffic_gen.sv
// Directed bench for axi_lite_traffic_gen against a small RAM subordinator with
// programmable ready delays, read stall and response-error injection.
module tb_axi_lite_traffic_gen;

   logic        clk;
   logic        ARESET, start;
   logic [1:0]  mode;
   logic [31:0] seed;
   logic        busy, done, pass, timeout;
   logic [3:0]  err_count;
   logic [4:0]  AWADDR, ARADDR;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] WDATA, RDATA;
   logic [1:0]  BRESP, RRESP;

   int checks, failures;

   // Subordinator knobs
   int   aw_delay, w_delay, bresp_bad, rresp_bad;
   logic ar_stall;
   logic        pl_en;
   logic [4:0]  pl_addr;
   logic [31:0] pl_data;

   // Subordinator state
   logic [31:0] ram [0:31];
   int          aw_wait, w_wait, wr_n, rd_n;
   logic        aw_got, w_got, bvalid_q, rvalid_q;
   logic [4:0]  aw_a;
   logic [31:0] w_d, rdata_q;
   logic [1:0]  bresp_q, rresp_q;

   // Run statistics
   int         cyc, done_cnt, busy_cnt, arv_cnt, first_ar_cyc, last_b_cyc, aw_n;
   logic [4:0] aw_log [0:7];

   axi_lite_traffic_gen #(
      .ABUS_SIZE(5), .DBUS_SIZE(32), .NUM_TXN(4), .BASE_ADDR(30), .ADDR_STRIDE(1), .TIMEOUT(16)
   ) dut (
      .ACLK(clk), .ARESET(ARESET), .start(start), .mode(mode), .seed(seed),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .timeout(timeout),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   wire aw_hs = AWVALID && AWREADY;
   wire w_hs  = WVALID && WREADY;
   wire wr_fire = (aw_got || aw_hs) && (w_got || w_hs);
   wire [4:0]  wa_eff = aw_hs ? AWADDR : aw_a;
   wire [31:0] wd_eff = w_hs ? WDATA : w_d;

   assign AWREADY = AWVALID && (aw_wait >= aw_delay);
   assign WREADY  = WVALID && (w_wait >= w_delay);
   assign BVALID  = bvalid_q;
   assign BRESP   = bresp_q;
   assign ARREADY = ARVALID && !ar_stall;
   assign RVALID  = rvalid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pl_en) ram[pl_addr] <= pl_data;
      if (ARESET) begin
         aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
         bvalid_q <= 1'b0; rvalid_q <= 1'b0; bresp_q <= 2'b0; rresp_q <= 2'b0;
         rdata_q <= 32'h0; wr_n <= 0; rd_n <= 0;
      end else begin
         aw_wait <= (AWVALID && !AWREADY) ? aw_wait + 1 : 0;
         w_wait  <= (WVALID && !WREADY) ? w_wait + 1 : 0;
         if (BVALID && BREADY) bvalid_q <= 1'b0;
         if (wr_fire) begin
            ram[wa_eff] <= wd_eff;
            bvalid_q <= 1'b1;
            bresp_q  <= (wr_n == bresp_bad) ? 2'd2 : 2'd0;
            wr_n     <= wr_n + 1;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
         end else begin
            if (aw_hs) begin aw_got <= 1'b1; aw_a <= AWADDR; end
            if (w_hs) begin w_got <= 1'b1; w_d <= WDATA; end
         end
         if (ARVALID && ARREADY) begin
            rvalid_q <= 1'b1;
            rdata_q  <= ram[ARADDR];
            rresp_q  <= (rd_n == rresp_bad) ? 2'd2 : 2'd0;
            rd_n     <= rd_n + 1;
         end else if (RVALID && RREADY) begin
            rvalid_q <= 1'b0;
         end
         if (!busy) begin wr_n <= 0; rd_n <= 0; end
      end
      if (start && !busy) begin
         done_cnt <= 0; busy_cnt <= 0; arv_cnt <= 0;
         first_ar_cyc <= -1; last_b_cyc <= -1; aw_n <= 0;
      end else begin
         if (done) done_cnt <= done_cnt + 1;
         if (busy) busy_cnt <= busy_cnt + 1;
         if (ARVALID) arv_cnt <= arv_cnt + 1;
         if (ARVALID && first_ar_cyc < 0) first_ar_cyc <= cyc;
         if (BVALID && BREADY) last_b_cyc <= cyc;
         if (aw_hs && aw_n < 8) begin aw_log[aw_n] <= AWADDR; aw_n <= aw_n + 1; end
      end
   end

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Leaves the caller at the negedge after the edge that sampled start; scrambles
   // mode/seed afterwards so an unlatched copy would show up.
   task automatic launch(input logic [1:0] m, input logic [31:0] s);
      @(negedge clk);
      start = 1'b1; mode = m; seed = s;
      @(negedge clk);
      start = 1'b0; mode = ~m; seed = ~s;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      repeat (2) @(negedge clk);
      ARESET = 1'b0;
      @(negedge clk);
      checks++;
      if ({AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 5'b0) begin
         failures++; $display("FAIL reset_handshake got=%b exp=00000",
                              {AWVALID, WVALID, BREADY, ARVALID, RREADY});
      end
      checks++;
      if ({busy, done, pass, timeout, err_count} !== 8'h0) begin
         failures++; $display("FAIL reset_status got=%h exp=00",
                              {busy, done, pass, timeout, err_count});
      end
      checks++;
      if ({AWADDR, ARADDR, WDATA} !== 42'h0) begin
         failures++; $display("FAIL reset_addr_data got=%h exp=0", {AWADDR, ARADDR, WDATA});
      end
      // start coincident with reset is dropped
      ARESET = 1'b1; start = 1'b1; mode = 2'd2;
      @(negedge clk);
      ARESET = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL reset_start_ignored got=%b exp=0", busy);
      end
   endtask

   task automatic test_mode2();
      bit ok;
      launch(2'd2, 32'h10);
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL m2_busy_early got=%b exp=0", busy);
      end
      @(negedge clk);
      checks++;
      if ({busy, AWVALID, WVALID, AWADDR, WDATA} !== {3'b111, 5'd30, 32'h10}) begin
         failures++; $display("FAIL m2_first_req got=%h exp=%h",
                              {busy, AWVALID, WVALID, AWADDR, WDATA}, {3'b111, 5'd30, 32'h10});
      end
      wait_done(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL m2_done got=0 exp=1"); end
      checks++;
      if ({done_cnt, busy_cnt} !== {32'd1, 32'd21}) begin
         failures++; $display("FAIL m2_done_busy_cycles got=%0d/%0d exp=1/21", done_cnt, busy_cnt);
      end
      checks++;
      if ({pass, timeout, err_count, busy} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
         failures++; $display("FAIL m2_status got=%b%b/%0d exp=10/0", pass, timeout, err_count);
      end
      checks++;
      if ({ram[30], ram[31], ram[0], ram[1]} !== {32'h10, 32'h11, 32'h12, 32'h13}) begin
         failures++; $display("FAIL m2_ram got=%h %h %h %h exp=10 11 12 13",
                              ram[30], ram[31], ram[0], ram[1]);
      end
   endtask

   task automatic test_mode1_check();
      bit ok;
      preload(5'd30, 32'd0); preload(5'd31, 32'd1); preload(5'd0, 32'd2); preload(5'd1, 32'd3);
      launch(2'd1, 32'd0);
      wait_done(ok);
      checks++;
      if ({ok, pass, err_count, busy_cnt} !== {2'b11, 4'd0, 32'd13}) begin
         failures++; $display("FAIL m1_clean got=%b%b/%0d/%0d exp=11/0/13",
                              ok, pass, err_count, busy_cnt);
      end
      preload(5'd0, 32'hFF);
      launch(2'd1, 32'd0);
      wait_done(ok);
      checks++;
      if ({ok, pass, err_count} !== {2'b10, 4'd1}) begin
         failures++; $display("FAIL m1_bad_data got=%b%b/%0d exp=10/1", ok, pass, err_count);
      end
      rresp_bad = 2;
      launch(2'd1, 32'd0);
      wait_done(ok);
      checks++;
      if ({ok, pass, err_count} !== {2'b10, 4'd1}) begin
         failures++; $display("FAIL m1_double_fault got=%b%b/%0d exp=10/1", ok, pass, err_count);
      end
      rresp_bad = 1;
      launch(2'd1, 32'd0);
      wait_done(ok);
      checks++;
      if ({ok, pass, err_count} !== {2'b10, 4'd2}) begin
         failures++; $display("FAIL m1_two_errors got=%b%b/%0d exp=10/2", ok, pass, err_count);
      end
      rresp_bad = -1;
   endtask

   task automatic test_mode3_delay();
      bit ok;
      aw_delay = 3; w_delay = 3;
      launch(2'd3, 32'h100);
      wait_done(ok);
      checks++;
      if ({ok, pass, err_count, busy_cnt} !== {2'b11, 4'd0, 32'd37}) begin
         failures++; $display("FAIL m3_delay got=%b%b/%0d/%0d exp=11/0/37",
                              ok, pass, err_count, busy_cnt);
      end
      checks++;
      if (!(last_b_cyc >= 0 && first_ar_cyc > last_b_cyc)) begin
         failures++; $display("FAIL m3_order got=lastB %0d firstAR %0d exp=lastB<firstAR",
                              last_b_cyc, first_ar_cyc);
      end
      checks++;
      if ({ram[30], ram[31], ram[0], ram[1]} !== {32'h100, 32'h101, 32'h102, 32'h103}) begin
         failures++; $display("FAIL m3_ram got=%h %h %h %h exp=100 101 102 103",
                              ram[30], ram[31], ram[0], ram[1]);
      end
      aw_delay = 4; w_delay = 1;
      launch(2'd3, 32'h7);
      wait_done(ok);
      checks++;
      if ({ok, pass, err_count, busy_cnt} !== {2'b11, 4'd0, 32'd41}) begin
         failures++; $display("FAIL m3_w_first got=%b%b/%0d/%0d exp=11/0/41",
                              ok, pass, err_count, busy_cnt);
      end
      aw_delay = 0; w_delay = 0;
   endtask

   task automatic test_timeout();
      bit ok;
      ar_stall = 1'b1;
      launch(2'd1, 32'd0);
      wait_done(ok);
      checks++;
      if ({ok, timeout, pass, err_count} !== {3'b110, 4'd0}) begin
         failures++; $display("FAIL tmo_status got=%b%b%b/%0d exp=110/0",
                              ok, timeout, pass, err_count);
      end
      checks++;
      if ({arv_cnt, busy_cnt, done_cnt} !== {32'd16, 32'd17, 32'd1}) begin
         failures++; $display("FAIL tmo_cycles got=%0d/%0d/%0d exp=16/17/1",
                              arv_cnt, busy_cnt, done_cnt);
      end
      checks++;
      if (ARVALID !== 1'b0) begin
         failures++; $display("FAIL tmo_arvalid_drop got=%b exp=0", ARVALID);
      end
      ar_stall = 1'b0;
   endtask

   task automatic test_mode0_wrap();
      bit ok;
      bresp_bad = 1;
      launch(2'd0, 32'h200);
      wait_done(ok);
      checks++;
      if ({aw_n, aw_log[0], aw_log[1], aw_log[2], aw_log[3]} !==
          {32'd4, 5'd30, 5'd31, 5'd0, 5'd1}) begin
         failures++; $display("FAIL m0_awaddr_seq got=%0d:%0d,%0d,%0d,%0d exp=4:30,31,0,1",
                              aw_n, aw_log[0], aw_log[1], aw_log[2], aw_log[3]);
      end
      checks++;
      if ({ok, pass, err_count, busy_cnt} !== {2'b10, 4'd1, 32'd13}) begin
         failures++; $display("FAIL m0_bresp got=%b%b/%0d/%0d exp=10/1/13",
                              ok, pass, err_count, busy_cnt);
      end
      checks++;
      if (ram[31] !== 32'h201) begin
         failures++; $display("FAIL m0_ram got=%h exp=201", ram[31]);
      end
      bresp_bad = -1;
   endtask

   task automatic test_reset_midrun();
      bit ok;
      bit seen;
      launch(2'd0, 32'h0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (BREADY) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen) begin failures++; $display("FAIL rst_mid_reach_wr_resp got=0 exp=1"); end
      ARESET = 1'b1;
      @(negedge clk);
      checks++;
      if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, busy, done, pass, timeout, err_count,
           AWADDR, ARADDR, WDATA} !== 55'h0) begin
         failures++; $display("FAIL rst_mid_outputs got=%b%b%b%b%b busy=%b exp=all zero",
                              AWVALID, WVALID, BREADY, ARVALID, RREADY, busy);
      end
      ARESET = 1'b0;
      launch(2'd2, 32'h40);
      wait_done(ok);
      checks++;
      if ({ok, pass, err_count, busy_cnt} !== {2'b11, 4'd0, 32'd21}) begin
         failures++; $display("FAIL rst_mid_rerun got=%b%b/%0d/%0d exp=11/0/21",
                              ok, pass, err_count, busy_cnt);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      launch(2'd2, 32'h55);
      repeat (3) @(negedge clk);
      start = 1'b1; mode = 2'd1;
      @(negedge clk);
      start = 1'b0;
      wait_done(ok);
      repeat (4) @(negedge clk);
      checks++;
      if ({ok, pass, busy, done_cnt, busy_cnt} !== {3'b110, 32'd1, 32'd21}) begin
         failures++; $display("FAIL b2b_start_ignored got=%b%b%b/%0d/%0d exp=110/1/21",
                              ok, pass, busy, done_cnt, busy_cnt);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      ARESET = 1'b1; start = 1'b0; mode = 2'd0; seed = 32'h0;
      pl_en = 1'b0; pl_addr = 5'd0; pl_data = 32'h0;
      aw_delay = 0; w_delay = 0; ar_stall = 1'b0; bresp_bad = -1; rresp_bad = -1;
      test_reset();
      test_mode2();
      test_mode1_check();
      test_mode3_delay();
      test_timeout();
      test_mode0_wrap();
      test_reset_midrun();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
